// File: rtl/lcd_spi_seq.sv
// lcd_spi_seq: SPI byte sequencer for an LCD panel.
// Runs the power-up reset sequence, then shifts mode-0 bytes with cs/dc control.
module lcd_spi_seq #(
    parameter int CLK_DIV  = 4,
    parameter int RST_LOW  = 5_000_000,
    parameter int RST_WAIT = 12_000_000,
    parameter int CS_GAP   = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_data,
    input  logic       i_cmd_dc,
    input  logic       i_cmd_last,
    input  logic       i_hw_reset_req,
    output logic       o_cs,
    output logic       o_scl,
    output logic       o_sda,
    output logic       o_dc,
    output logic       o_lcd_reset,
    output logic       o_byte_done,
    output logic       o_init_done,
    output logic       o_busy
);

    // A parameter value of 0 behaves as 1.
    localparam int CD = (CLK_DIV  < 1) ? 1 : CLK_DIV;
    localparam int RL = (RST_LOW  < 1) ? 1 : RST_LOW;
    localparam int RW = (RST_WAIT < 1) ? 1 : RST_WAIT;
    localparam int CG = (CS_GAP   < 1) ? 1 : CS_GAP;

    localparam int DMAX = (RL > RW) ? ((RL > CG) ? RL : CG)
                                    : ((RW > CG) ? RW : CG);
    localparam int DW = $clog2(DMAX + 1);
    localparam int VW = $clog2(CD + 1);

    localparam logic [DW-1:0] RL_END = DW'(RL - 1);
    localparam logic [DW-1:0] RW_END = DW'(RW - 1);
    localparam logic [DW-1:0] CG_END = DW'(CG - 1);
    localparam logic [VW-1:0] CD_END = VW'(CD - 1);

    typedef enum logic [2:0] {
        S_POR_LOW,
        S_POR_WAIT,
        S_IDLE,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t        r_state, w_state;
    logic [DW-1:0] r_cnt,   w_cnt;
    logic [VW-1:0] r_div,   w_div;
    logic [2:0]    r_bit,   w_bit;
    logic [6:0]    r_sh,    w_sh;
    logic          r_last,  w_last;
    logic          r_cs,    w_cs;
    logic          r_scl,   w_scl;
    logic          r_sda,   w_sda;
    logic          r_dc,    w_dc;
    logic          r_lrst,  w_lrst;
    logic          r_done,  w_done;
    logic          r_init,  w_init;
    logic          r_busy,  w_busy;
    logic          w_xfer;

    assign o_cmd_ready = ((r_state == S_IDLE) || (r_state == S_HOLD))
                         && !i_hw_reset_req;
    assign w_xfer = i_cmd_valid && o_cmd_ready;

    assign o_cs        = r_cs;
    assign o_scl       = r_scl;
    assign o_sda       = r_sda;
    assign o_dc        = r_dc;
    assign o_lcd_reset = r_lrst;
    assign o_byte_done = r_done;
    assign o_init_done = r_init;
    assign o_busy      = r_busy;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_div   = r_div;
        w_bit   = r_bit;
        w_sh    = r_sh;
        w_last  = r_last;
        w_cs    = r_cs;
        w_scl   = r_scl;
        w_sda   = r_sda;
        w_dc    = r_dc;
        w_lrst  = r_lrst;
        w_done  = 1'b0;
        w_init  = r_init;
        case (r_state)
            S_POR_LOW: begin
                w_lrst = 1'b0;
                w_cs   = 1'b1;
                if (r_cnt == RL_END) begin
                    w_state = S_POR_WAIT;
                    w_cnt   = '0;
                    w_lrst  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_POR_WAIT: begin
                if (r_cnt == RW_END) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                    w_init  = 1'b1;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_IDLE, S_HOLD: begin
                if (i_hw_reset_req) begin
                    w_state = S_POR_LOW;
                    w_cnt   = '0;
                    w_lrst  = 1'b0;
                    w_cs    = 1'b1;
                    w_scl   = 1'b0;
                    w_init  = 1'b0;
                end else if (w_xfer) begin
                    w_state = S_SHIFT;
                    w_sh    = i_cmd_data[6:0];
                    w_sda   = i_cmd_data[7];
                    w_dc    = i_cmd_dc;
                    w_last  = i_cmd_last;
                    w_cs    = 1'b0;
                    w_scl   = 1'b0;
                    w_div   = '0;
                    w_bit   = '0;
                end
            end
            S_SHIFT: begin
                if (r_div == CD_END) begin
                    w_div = '0;
                    if (!r_scl) begin
                        w_scl = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit or finish.
                        w_scl = 1'b0;
                        if (r_bit == 3'd7) begin
                            w_done  = 1'b1;
                            w_cnt   = '0;
                            w_cs    = r_last;
                            w_state = r_last ? S_GAP : S_HOLD;
                        end else begin
                            w_bit = r_bit + 3'd1;
                            w_sda = r_sh[6];
                            w_sh  = {r_sh[5:0], 1'b0};
                        end
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_GAP: begin
                if (r_cnt == CG_END) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_POR_LOW;
                w_cnt   = '0;
                w_cs    = 1'b1;
                w_lrst  = 1'b0;
            end
        endcase
        w_busy = !((w_state == S_IDLE) || (w_state == S_HOLD));
    end

    // State and registered outputs; reset restarts the power-up sequence.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_POR_LOW;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_last  <= 1'b0;
            r_cs    <= 1'b1;
            r_scl   <= 1'b0;
            r_sda   <= 1'b0;
            r_dc    <= 1'b0;
            r_lrst  <= 1'b0;
            r_done  <= 1'b0;
            r_init  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_div   <= w_div;
            r_bit   <= w_bit;
            r_sh    <= w_sh;
            r_last  <= w_last;
            r_cs    <= w_cs;
            r_scl   <= w_scl;
            r_sda   <= w_sda;
            r_dc    <= w_dc;
            r_lrst  <= w_lrst;
            r_done  <= w_done;
            r_init  <= w_init;
            r_busy  <= w_busy;
        end
    end

endmodule

// File: tb/tb_lcd_spi_seq.sv
// tb_lcd_spi_seq: directed bench for lcd_spi_seq.
// Table of single-byte vectors plus hand-written HOLD, hw-reset and abort cases.
module tb_lcd_spi_seq;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       valid  = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       dc_i   = 1'b0;
    logic       last_i = 1'b0;
    logic       hwr    = 1'b0;

    logic o_ready, o_cs, o_scl, o_sda, o_dc, o_lrst;
    logic o_done, o_init, o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    lcd_spi_seq #(
        .CLK_DIV (2),
        .RST_LOW (4),
        .RST_WAIT(6),
        .CS_GAP  (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_cmd_valid   (valid),
        .o_cmd_ready   (o_ready),
        .i_cmd_data    (data_i),
        .i_cmd_dc      (dc_i),
        .i_cmd_last    (last_i),
        .i_hw_reset_req(hwr),
        .o_cs          (o_cs),
        .o_scl         (o_scl),
        .o_sda         (o_sda),
        .o_dc          (o_dc),
        .o_lcd_reset   (o_lrst),
        .o_byte_done   (o_done),
        .o_init_done   (o_init),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        logic       scram;
        logic [7:0] exp_bits;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at the negedge sample right after entry into POR_LOW.
    task automatic por_check(input string tag);
        int k_lcd = -1;
        int k_init = -1;
        int cs_low = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (o_cs == 1'b0) cs_low++;
            if (k_lcd < 0 && o_lrst) k_lcd = k;
            if (k_init < 0 && o_init) k_init = k;
            if (k_init >= 0) break;
        end
        chk({tag, " lcd_reset low cycles"}, k_lcd, 4);
        chk({tag, " init delay after lcd_reset"}, k_init - k_lcd, 6);
        chk({tag, " cs low during por"}, cs_low, 0);
        chk({tag, " ready after init"}, int'(o_ready), 1);
        chk({tag, " busy after init"}, int'(o_busy), 0);
    endtask

    // One byte with last=1, started at a negedge in IDLE.
    task automatic send_vec(input int idx, input vec_t v);
        logic [7:0] bits = 8'h00;
        logic prev = 1'b0;
        int done_at = -1;
        int extra = 0;
        int cs_low = 0;
        int ready_at = -1;
        int dc_bad = 0;
        string t;
        t = $sformatf("vec%0d", idx);
        chk({t, " ready before"}, int'(o_ready), 1);
        valid  = 1'b1;
        data_i = v.data;
        dc_i   = v.dc;
        last_i = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (!o_cs) cs_low++;
            if (!o_cs && o_dc !== v.dc) dc_bad++;
            if (o_scl && !prev) bits = {bits[6:0], o_sda};
            prev = o_scl;
            if (o_done) begin
                if (done_at < 0) done_at = cyc;
                else extra++;
            end
            if (o_ready) begin
                ready_at = cyc;
                valid = 1'b0;
                break;
            end
            if (v.scram && done_at < 0) begin
                valid  = 1'b1;
                data_i = 8'($urandom());
                dc_i   = 1'($urandom());
                last_i = 1'($urandom());
            end else begin
                valid = 1'b0;
            end
        end
        valid  = 1'b0;
        dc_i   = 1'b0;
        last_i = 1'b0;
        chk({t, " sda bits"}, int'(bits), int'(v.exp_bits));
        chk({t, " cs low cycles"}, cs_low, 32);
        chk({t, " byte_done cycle"}, done_at, 32);
        chk({t, " extra byte_done"}, extra, 0);
        chk({t, " dc during byte"}, dc_bad, 0);
        chk({t, " ready cycle"}, ready_at, 35);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bits16;
        logic prev;
        int d1, d2, cs_low, dc0, dc33, scl32, rdy32, ready_at, nd;

        tbl[0] = '{8'h29, 1'b0, 1'b0, 8'h29};
        tbl[1] = '{8'hA5, 1'b1, 1'b0, 8'hA5};
        tbl[2] = '{8'hFF, 1'b0, 1'b0, 8'hFF};
        tbl[3] = '{8'h00, 1'b1, 1'b0, 8'h00};
        tbl[4] = '{8'h6C, 1'b1, 1'b1, 8'h6C};
        tbl[5] = '{8'h81, 1'b0, 1'b1, 8'h81};

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst cs", int'(o_cs), 1);
        chk("rst scl", int'(o_scl), 0);
        chk("rst sda", int'(o_sda), 0);
        chk("rst dc", int'(o_dc), 0);
        chk("rst lcd_reset", int'(o_lrst), 0);
        chk("rst byte_done", int'(o_done), 0);
        chk("rst init_done", int'(o_init), 0);
        chk("rst busy", int'(o_busy), 1);
        chk("rst ready", int'(o_ready), 0);
        reset = 1'b0;
        por_check("por");

        for (int i = 0; i < 6; i++) send_vec(i, tbl[i]);

        // Two bytes under one cs: 0x2A cmd (last=0) then 0x00 data held valid.
        valid  = 1'b1;
        data_i = 8'h2A;
        dc_i   = 1'b0;
        last_i = 1'b0;
        @(posedge clk);
        bits16 = '0; prev = 1'b0;
        d1 = -1; d2 = -1; cs_low = 0; dc0 = -1; dc33 = -1;
        scl32 = -1; rdy32 = -1; ready_at = -1;
        for (int cyc = 0; cyc < 90; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                data_i = 8'h00;
                dc_i   = 1'b1;
                last_i = 1'b1;
                dc0    = int'(o_dc);
            end
            if (cyc == 33) begin
                valid = 1'b0;
                dc33  = int'(o_dc);
            end
            if (cyc == 32) begin
                scl32 = int'(o_scl);
                rdy32 = int'(o_ready);
            end
            if (!o_cs) cs_low++;
            if (o_scl && !prev) bits16 = {bits16[14:0], o_sda};
            prev = o_scl;
            if (o_done) begin
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (d2 >= 0 && o_ready) begin
                ready_at = cyc;
                break;
            end
        end
        valid = 1'b0; dc_i = 1'b0; last_i = 1'b0;
        chk("hold bits", int'(bits16), 32'h2A00);
        chk("hold first byte_done", d1, 32);
        chk("hold byte_done spacing", d2 - d1, 33);
        chk("hold cs low cycles", cs_low, 65);
        chk("hold dc byte1", dc0, 0);
        chk("hold dc byte2", dc33, 1);
        chk("hold scl in HOLD", scl32, 0);
        chk("hold ready in HOLD", rdy32, 1);
        chk("hold ready after gap", ready_at, 68);

        // hw_reset_req while in HOLD.
        valid  = 1'b1;
        data_i = 8'h55;
        last_i = 1'b0;
        @(posedge clk);
        nd = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            valid = 1'b0;
            if (o_done) begin
                nd = cyc;
                break;
            end
        end
        chk("hold-hwr byte_done cycle", nd, 32);
        hwr = 1'b1;
        #1;
        chk("hold-hwr ready with req", int'(o_ready), 0);
        @(posedge clk);
        @(negedge clk);
        hwr = 1'b0;
        chk("hold-hwr cs", int'(o_cs), 1);
        chk("hold-hwr init_done", int'(o_init), 0);
        por_check("hold-hwr");

        // hw_reset_req together with cmd_valid in IDLE.
        hwr    = 1'b1;
        valid  = 1'b1;
        data_i = 8'hFF;
        last_i = 1'b1;
        #1;
        chk("idle-hwr ready with req", int'(o_ready), 0);
        @(posedge clk);
        @(negedge clk);
        hwr   = 1'b0;
        valid = 1'b0;
        chk("idle-hwr init_done", int'(o_init), 0);
        chk("idle-hwr busy", int'(o_busy), 1);
        por_check("idle-hwr");

        // Reset during the 10th SHIFT cycle.
        valid  = 1'b1;
        data_i = 8'hC3;
        last_i = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            valid = 1'b0;
            if (o_done) nd++;
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort cs", int'(o_cs), 1);
        chk("abort byte_done", int'(o_done) + nd, 0);
        chk("abort lcd_reset", int'(o_lrst), 0);
        chk("abort init_done", int'(o_init), 0);
        reset = 1'b0;
        por_check("abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_spi_seq.md
LCD_SPI_SEQ -- requirements
Module: lcd_spi_seq

Interface
REQ-001 Parameter CLK_DIV, default 4, meaning: SCL half-period in clk cycles (legal range 1..255).
REQ-002 Parameter RST_LOW, default 5_000_000, meaning: lcd_reset low time in clk cycles.
REQ-003 Parameter RST_WAIT, default 12_000_000, meaning: post-reset settle time in clk cycles.
REQ-004 Parameter CS_GAP, default 2, meaning: minimum cs-high cycles between transactions.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  byte request valid.
REQ-008 cmd_ready  output  1  block can accept a byte this cycle.
REQ-009 cmd_data  input  8  byte to send, MSB first.
REQ-010 cmd_dc  input  1  0 = command byte, 1 = data byte.
REQ-011 cmd_last  input  1  1 = release cs after this byte.
REQ-012 hw_reset_req  input  1  one-cycle request to re-run the panel hardware-reset sequence.
REQ-013 cs, scl, sda, dc, lcd_reset  output  1 each  panel pins; cs active-low.
REQ-014 byte_done  output  1  one-cycle pulse when a byte finishes shifting.
REQ-015 init_done  output  1  high once the power-up sequence completes.
REQ-016 busy  output  1  high in every state except IDLE and HOLD.

Function
REQ-017 States SHALL be POR_LOW, POR_WAIT, IDLE, SHIFT, HOLD, GAP; all outputs registered except cmd_ready.
REQ-018 POR_LOW SHALL drive lcd_reset=0 for exactly RST_LOW cycles, then enter POR_WAIT with lcd_reset=1.
REQ-019 POR_WAIT SHALL last exactly RST_WAIT cycles, then enter IDLE and set init_done=1.
REQ-020 cmd_ready SHALL equal (state==IDLE or state==HOLD) and not hw_reset_req; a transfer occurs on cmd_valid and cmd_ready.
REQ-021 On transfer, the block SHALL latch data, dc and last, and enter SHIFT the next cycle with cs=0, dc=latched dc, sda=bit 7, scl=0.
REQ-022 SPI mode 0 applies: each bit SHALL be scl low for CLK_DIV cycles, then high for CLK_DIV cycles; sda updates only while scl is low, on the scl falling-edge cycle.
REQ-023 One byte SHALL occupy exactly 16*CLK_DIV cycles in SHIFT; byte_done SHALL pulse on the cycle scl returns low after bit 0.
REQ-024 After byte_done with last=1, the block SHALL drive cs=1 and enter GAP for CS_GAP cycles, then IDLE.
REQ-025 After byte_done with last=0, the block SHALL enter HOLD with cs=0 and scl=0; the next transfer from HOLD SHALL start SHIFT with no cs toggle.
REQ-026 In HOLD, hw_reset_req SHALL drive cs=1 and enter POR_LOW.
REQ-027 In IDLE, hw_reset_req SHALL enter POR_LOW and clear init_done; a simultaneous cmd_valid is not accepted.
REQ-028 hw_reset_req SHALL be ignored in SHIFT, GAP, POR_LOW and POR_WAIT.
REQ-029 cmd_data, cmd_dc and cmd_last SHALL be ignored outside a transfer cycle; changes during SHIFT have no effect.
REQ-030 All delay counters SHALL be sized by $clog2 of their parameter and SHALL not wrap; a value of 0 is treated as 1.

Reset
REQ-031 When reset is high at a rising clk edge, the next state SHALL be POR_LOW with cs=1, scl=0, sda=0, dc=0, lcd_reset=0, byte_done=0, init_done=0, busy=1; cmd_ready follows REQ-020.
REQ-032 A reset asserted mid-SHIFT or mid-HOLD SHALL abort the byte with no byte_done; cs SHALL be 1 on the following edge.

Verification (RST_LOW=4, RST_WAIT=6, CLK_DIV=2, CS_GAP=3)
REQ-033 Release reset -> lcd_reset low 4 cycles, high; init_done rises 6 cycles later; cmd_ready=1.
REQ-034 Send 0x29, dc=0, last=1 -> cs low 32 cycles; 8 scl rising edges sample 0,0,1,0,1,0,0,1; byte_done at acceptance+32; cs high, cmd_ready after 3 more cycles.
REQ-035 Send 0x2A, last=0, then 0x00, dc=1, last=1 held valid -> cs stays low across both bytes; dc rises for byte 2; two byte_done pulses 33 cycles apart (HOLD accept plus 32 shift cycles).
REQ-036 Assert hw_reset_req and cmd_valid together in IDLE -> no transfer; lcd_reset low 4 cycles; init_done low until POR_WAIT completes.
REQ-037 Assert reset at the 10th SHIFT cycle -> cs=1 next cycle, no byte_done, POR sequence restarts.
REQ-038 Hold cmd_valid with data changing every cycle during SHIFT -> sda matches the byte latched at acceptance only.
